// File: rtl/mouse_pkg.sv
// Shared PS/2 mouse definitions: receiver/transmitter state encodings,
// timeout default and error-code bit positions.
package mouse_pkg;

  localparam int PS2_TIMEOUT_CYCLES = 10000;

  localparam int ERR_PARITY = 0;
  localparam int ERR_STOP   = 1;

  typedef enum logic [1:0] {
    RX_IDLE   = 2'd0,
    RX_DATA   = 2'd1,
    RX_PARITY = 2'd2,
    RX_STOP   = 2'd3
  } rx_state_e;

  typedef enum logic [2:0] {
    TX_IDLE      = 3'd0,
    TX_CLK_LOW   = 3'd1,
    TX_START     = 3'd2,
    TX_DATA      = 3'd3,
    TX_PARITY    = 3'd4,
    TX_STOP      = 3'd5,
    TX_WAIT_ACK  = 3'd6,
    TX_DONE      = 3'd7
  } tx_state_e;

endpackage

// File: rtl/ps2_edge_detect.sv
// Three-flop synchroniser on a PS/2 line with a one-cycle edge pulse;
// FALLING selects which transition is reported.
module ps2_edge_detect #(
  parameter bit FALLING = 1'b1
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_line,
  output logic o_edge
);

  logic [2:0] r_dly;

  // Idle PS/2 lines sit high, so resetting to ones avoids a spurious edge.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_dly <= 3'b111;
    else          r_dly <= {r_dly[1:0], i_line};
  end

  generate
    if (FALLING) begin : g_fall
      assign o_edge = r_dly[2] & ~r_dly[1];
    end else begin : g_rise
      assign o_edge = ~r_dly[2] & r_dly[1];
    end
  endgenerate

endmodule

// File: rtl/mouse_receiver.sv
// PS/2 host receiver: deframes start, 8 data bits LSB first, odd parity and
// stop from the mouse, reporting the byte plus parity/stop error flags.
module mouse_receiver
  import mouse_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = PS2_TIMEOUT_CYCLES
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       CLK_MOUSE_IN,
  input  logic       DATA_MOUSE_IN,
  input  logic       READ_ENABLE,
  output logic [7:0] BYTE_READ,
  output logic [1:0] BYTE_ERROR_CODE,
  output logic       BYTE_READY
);

  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

  rx_state_e   r_state;
  logic [7:0]  r_shift;
  logic [2:0]  r_bit_cnt;
  logic [15:0] r_to_cnt;
  logic        r_par_err;
  logic [1:0]  r_data_sync;

  logic        w_fall;
  logic        w_data_s;
  logic        w_timeout;

  ps2_edge_detect #(.FALLING(1'b1)) u_clk_edge (
    .i_clk   (CLK),
    .i_rst_n (RESET),
    .i_line  (CLK_MOUSE_IN),
    .o_edge  (w_fall)
  );

  // Two flops keep data aligned with the clock chain's fall detection point.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) r_data_sync <= 2'b11;
    else        r_data_sync <= {r_data_sync[0], DATA_MOUSE_IN};
  end

  assign w_data_s  = r_data_sync[1];
  assign w_timeout = (r_state != RX_IDLE) && (r_to_cnt == TO_LAST);

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_to_cnt <= '0;
    end else if (r_state == RX_IDLE || w_fall) begin
      r_to_cnt <= '0;
    end else if (r_to_cnt != 16'hFFFF) begin
      r_to_cnt <= r_to_cnt + 16'd1;
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_state         <= RX_IDLE;
      r_shift         <= '0;
      r_bit_cnt       <= '0;
      r_par_err       <= 1'b0;
      BYTE_READ       <= '0;
      BYTE_ERROR_CODE <= '0;
      BYTE_READY      <= 1'b0;
    end else begin
      BYTE_READY <= 1'b0;
      // A stalled mouse abandons the frame; this beats a coincident edge.
      if (w_timeout) begin
        r_state   <= RX_IDLE;
        r_bit_cnt <= '0;
      end else if (w_fall) begin
        case (r_state)
          RX_IDLE: begin
            if (READ_ENABLE && !w_data_s) begin
              r_state   <= RX_DATA;
              r_bit_cnt <= '0;
            end
          end
          RX_DATA: begin
            r_shift   <= {w_data_s, r_shift[7:1]};
            r_bit_cnt <= r_bit_cnt + 3'd1;
            if (r_bit_cnt == 3'd7) r_state <= RX_PARITY;
          end
          RX_PARITY: begin
            r_par_err <= (w_data_s != ~^r_shift);
            r_state   <= RX_STOP;
          end
          RX_STOP: begin
            BYTE_READ                   <= r_shift;
            BYTE_ERROR_CODE[ERR_STOP]   <= ~w_data_s;
            BYTE_ERROR_CODE[ERR_PARITY] <= r_par_err;
            BYTE_READY                  <= 1'b1;
            r_state                     <= RX_IDLE;
          end
          default: r_state <= RX_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mouse_receiver.sv
// Directed bench for mouse_receiver; mouse clock and timeout are scaled down
// by the same ratio as the real 12.5 kHz / 200 us figures to keep runs short.
module tb_mouse_receiver;

  localparam int TO    = 250;   // timeout, 2.5 mouse periods
  localparam int HALF  = 50;    // half mouse period in CLK cycles
  localparam int SLOW  = 180;   // stretched high phase, still under timeout
  localparam int STALL = 375;   // clock stall, well past timeout

  logic       clk = 1'b0;
  logic       rst_n;
  logic       mclk;
  logic       mdat;
  logic       re;
  logic [7:0] byte_read;
  logic [1:0] err_code;
  logic       ready;

  int n_cmp = 0;
  int n_err = 0;
  int n_pulse = 0;
  logic [7:0] q_byte[$];
  logic [1:0] q_err[$];

  always #10 clk = ~clk;

  mouse_receiver #(.TIMEOUT_CYCLES(TO)) dut (
    .CLK             (clk),
    .RESET           (rst_n),
    .CLK_MOUSE_IN    (mclk),
    .DATA_MOUSE_IN   (mdat),
    .READ_ENABLE     (re),
    .BYTE_READ       (byte_read),
    .BYTE_ERROR_CODE (err_code),
    .BYTE_READY      (ready)
  );

  // A pulse wider than one cycle shows up as extra counted samples.
  always @(negedge clk) begin
    if (ready === 1'b1) begin
      n_pulse <= n_pulse + 1;
      q_byte.push_back(byte_read);
      q_err.push_back(err_code);
    end
  end

  function automatic logic [10:0] mk(input logic [7:0] d, input logic par, input logic stp);
    return {stp, par, d, 1'b0};
  endfunction

  task automatic send_bits(input logic [10:0] f, input int lo, input int hi, input int slow);
    for (int i = lo; i <= hi; i++) begin
      mdat = f[i];
      repeat ((i == slow) ? SLOW : HALF) @(negedge clk);
      mclk = 1'b0;
      repeat (HALF) @(negedge clk);
      mclk = 1'b1;
    end
  endtask

  task automatic send_frame(input logic [10:0] f);
    send_bits(f, 0, 10, -1);
    mdat = 1'b1;
  endtask

  task automatic pop(output logic [7:0] b, output logic [1:0] e);
    b = (q_byte.size() > 0) ? q_byte.pop_front() : 8'hxx;
    e = (q_err.size() > 0) ? q_err.pop_front() : 2'bxx;
  endtask

  task automatic expect_frame(input string nm, input int n0, input logic [7:0] eb, input logic [1:0] ee);
    logic [7:0] b;
    logic [1:0] e;
    n_cmp++;
    if (n_pulse - n0 !== 1) begin
      n_err++;
      $display("FAIL %s pulses: got %0d want 1", nm, n_pulse - n0);
    end
    pop(b, e);
    n_cmp++;
    if (b !== eb) begin
      n_err++;
      $display("FAIL %s byte: got %h want %h", nm, b, eb);
    end
    n_cmp++;
    if (e !== ee) begin
      n_err++;
      $display("FAIL %s code: got %b want %b", nm, e, ee);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; mclk = 1'b1; mdat = 1'b1; re = 1'b1;
    repeat (5) @(negedge clk);
    n_cmp++;
    if (byte_read !== 8'h00) begin n_err++; $display("FAIL reset byte: got %h want 00", byte_read); end
    n_cmp++;
    if (err_code !== 2'b00) begin n_err++; $display("FAIL reset code: got %b want 00", err_code); end
    n_cmp++;
    if (ready !== 1'b0) begin n_err++; $display("FAIL reset ready: got %b want 0", ready); end
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
  endtask

  task automatic test_basic();
    int n0 = n_pulse;
    send_frame(mk(8'hFA, 1'b1, 1'b1));
    repeat (20) @(negedge clk);
    expect_frame("fa", n0, 8'hFA, 2'b00);
  endtask

  task automatic test_back_to_back();
    int n0 = n_pulse;
    send_frame(mk(8'hAA, 1'b1, 1'b1));
    send_frame(mk(8'h08, 1'b0, 1'b1));
    repeat (20) @(negedge clk);
    n_cmp++;
    if (n_pulse - n0 !== 2) begin
      n_err++;
      $display("FAIL b2b pulses: got %0d want 2", n_pulse - n0);
    end
    expect_frame("b2b_aa", n_pulse - 1, 8'hAA, 2'b00);
    expect_frame("b2b_08", n_pulse - 1, 8'h08, 2'b00);
  endtask

  task automatic test_parity_err();
    int n0 = n_pulse;
    send_frame(mk(8'hFA, 1'b0, 1'b1));
    repeat (20) @(negedge clk);
    expect_frame("par_err", n0, 8'hFA, 2'b01);
  endtask

  task automatic test_stop_err();
    int n0 = n_pulse;
    send_frame(mk(8'h00, 1'b1, 1'b0));
    repeat (20) @(negedge clk);
    expect_frame("stop_err", n0, 8'h00, 2'b10);
  endtask

  task automatic test_timeout();
    int n0 = n_pulse;
    send_bits(mk(8'h5A, 1'b1, 1'b1), 0, 4, -1);
    mdat = 1'b1;
    repeat (STALL) @(negedge clk);
    n_cmp++;
    if (n_pulse - n0 !== 0) begin n_err++; $display("FAIL to_partial pulses: got %0d want 0", n_pulse - n0); end
    n_cmp++;
    if (byte_read !== 8'h00) begin n_err++; $display("FAIL to_partial byte: got %h want 00", byte_read); end
    n_cmp++;
    if (err_code !== 2'b10) begin n_err++; $display("FAIL to_partial code: got %b want 10", err_code); end
    send_frame(mk(8'h55, 1'b1, 1'b1));
    repeat (20) @(negedge clk);
    expect_frame("to_55", n0, 8'h55, 2'b00);
  endtask

  task automatic test_slow_edge();
    int n0 = n_pulse;
    send_bits(mk(8'hC3, 1'b1, 1'b1), 0, 10, 5);
    mdat = 1'b1;
    repeat (20) @(negedge clk);
    expect_frame("slow_c3", n0, 8'hC3, 2'b00);
  endtask

  task automatic test_re_midframe();
    int n0 = n_pulse;
    send_bits(mk(8'h81, 1'b1, 1'b1), 0, 2, -1);
    re = 1'b0;
    send_bits(mk(8'h81, 1'b1, 1'b1), 3, 10, -1);
    mdat = 1'b1;
    repeat (20) @(negedge clk);
    expect_frame("re_mid", n0, 8'h81, 2'b00);
  endtask

  task automatic test_re_disable();
    int n0 = n_pulse;
    re = 1'b0;
    send_frame(mk(8'hFA, 1'b1, 1'b1));
    repeat (20) @(negedge clk);
    n_cmp++;
    if (n_pulse - n0 !== 0) begin n_err++; $display("FAIL re_off pulses: got %0d want 0", n_pulse - n0); end
    n_cmp++;
    if (byte_read !== 8'h81) begin n_err++; $display("FAIL re_off byte: got %h want 81", byte_read); end
    n_cmp++;
    if (err_code !== 2'b00) begin n_err++; $display("FAIL re_off code: got %b want 00", err_code); end
    re = 1'b1;
    repeat (HALF) @(negedge clk);
  endtask

  task automatic test_reset_midframe();
    int n0;
    send_bits(mk(8'hFF, 1'b1, 1'b1), 0, 6, -1);
    mdat = 1'b1;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (byte_read !== 8'h00) begin n_err++; $display("FAIL rst_mid byte: got %h want 00", byte_read); end
    n_cmp++;
    if (err_code !== 2'b00) begin n_err++; $display("FAIL rst_mid code: got %b want 00", err_code); end
    rst_n = 1'b1;
    repeat (HALF) @(negedge clk);
    n0 = n_pulse;
    send_frame(mk(8'h3C, 1'b1, 1'b1));
    repeat (20) @(negedge clk);
    expect_frame("rst_3c", n0, 8'h3C, 2'b00);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_parity_err();
    test_stop_err();
    test_timeout();
    test_slow_edge();
    test_re_midframe();
    test_re_disable();
    test_reset_midframe();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mouse_receiver.md
# mouse_receiver

PS/2 host-side receiver for the mouse interface. It samples the mouse-driven clock and data lines, deframes one 11-bit mouse-to-host frame (start, 8 data bits LSB first, odd parity, stop), and presents the byte with error flags to the mouse master state machine. It sits beside the mouse transmitter on the same bidirectional lines and consumes everything the mouse sends: acknowledge bytes, self-test results and movement packets.

## Interface
- `TIMEOUT_CYCLES`, default 10000: maximum CLK cycles between consecutive mouse-clock falling edges inside a frame (200 µs at 50 MHz).
- `CLK` input 1: system clock, 50 MHz.
- `RESET` input 1: asynchronous, active-low reset. The clock and reset are fixed as one clock with an asynchronous active-low reset.
- `CLK_MOUSE_IN` input 1: raw PS/2 clock line.
- `DATA_MOUSE_IN` input 1: raw PS/2 data line.
- `READ_ENABLE` input 1: high lets the block accept a new frame. The master drives it low while the transmitter owns the lines.
- `BYTE_READ` output 8: last received data byte.
- `BYTE_ERROR_CODE` output 2: bit0 is a parity error, bit1 is a stop-bit error.
- `BYTE_READY` output 1: one-cycle pulse when `BYTE_READ` and `BYTE_ERROR_CODE` update.

## Operation
- **Synchronisers**
  - `CLK_MOUSE_IN` feeds a 3-flop shift chain `clk_dly`, reset value 3'b111.
  - A falling edge `fall_vld` is `clk_dly[2]==1 && clk_dly[1]==0`.
  - `DATA_MOUSE_IN` feeds a 2-flop chain, reset value 2'b11. Its output `data_s` is the sample used on `fall_vld`.
- **FSM states:** IDLE, DATA, PARITY, STOP. All transitions below happen only on `fall_vld` unless stated otherwise.
  - **IDLE:** requires `READ_ENABLE==1` and `data_s==0` (start bit), then goes to DATA with `bit_cnt=0`. If `data_s==1`, or `READ_ENABLE==0`, the edge is ignored and the FSM stays in IDLE.
  - **DATA:** shifts `data_s` into `shift_reg` MSB-first, i.e. `{data_s, shift_reg[7:1]}`, so the byte is LSB first. `bit_cnt` increments. After the edge taken at `bit_cnt==7`, the FSM goes to PARITY.
  - **PARITY:** latches `par_err = (data_s != ~^shift_reg)`, then goes to STOP.
  - **STOP:** on the edge it registers `BYTE_READ<=shift_reg`, `BYTE_ERROR_CODE<={~data_s, par_err}` and `BYTE_READY<=1`, then returns to IDLE.
- `READ_ENABLE` is sampled only in IDLE. A frame already in progress completes even if `READ_ENABLE` falls.
- **Timeout**
  - The 16-bit `to_cnt` clears in IDLE and on every `fall_vld`. Otherwise it increments, saturating.
  - In DATA, PARITY or STOP, `to_cnt==TIMEOUT_CYCLES-1` forces IDLE. The frame is discarded: no `BYTE_READY`, and `BYTE_READ`/`BYTE_ERROR_CODE` are unchanged.
  - If a timeout and `fall_vld` occur in the same cycle, the timeout wins.
- **Errored frames** still pulse `BYTE_READY`. The master decides whether to retry.
- **Reset**
  - Asserting `RESET` at any time, including mid-frame, returns the FSM to IDLE and clears `shift_reg`, `bit_cnt` and `to_cnt`.
  - Output reset values: `BYTE_READ=8'h00`, `BYTE_ERROR_CODE=2'b00`, `BYTE_READY=0`.

## Timing
- Edge detect latency: `fall_vld` is high 3 CLK after the `CLK_MOUSE_IN` pin falls, for exactly 1 CLK per edge.
- `BYTE_READY` rises on the CLK edge after the cycle in which the 11th `fall_vld` is detected, and stays high for exactly 1 cycle.
- `BYTE_READ`/`BYTE_ERROR_CODE` change on the same edge as the `BYTE_READY` rise and are held until the next `BYTE_READY`.
- The mouse clock runs at 10–16.7 kHz, so there are ≥3000 CLK cycles between edges. Back-to-back frames need no idle gap beyond one mouse clock period.
- Glitches shorter than 1 CLK are not filtered. No further debouncing is required.

## Structure
- **Shared package `mouse_pkg`:**
  - receiver state enum (IDLE, DATA, PARITY, STOP);
  - transmitter state encodings;
  - `PS2_TIMEOUT_CYCLES = 10000`;
  - error-bit indices `ERR_PARITY=0`, `ERR_STOP=1`.
- **Sub-module `ps2_edge_detect`:** synchroniser plus rising/falling edge pulses, parameterised on edge polarity. It is reused by the transmitter, which needs rising edges.

## Test plan
- Frame 0xFA (bits 0,1,0,1,1,1,1,1), parity 1, stop 1, at a 12.5 kHz mouse clock. Required: one `BYTE_READY` pulse, `BYTE_READ=8'hFA`, `BYTE_ERROR_CODE=2'b00`.
- Frame 0x08, parity 0, stop 1, sent back-to-back after an 0xAA frame (parity 1). Required: two pulses, reading 8'hAA then 8'h08, both with code 2'b00.
- Frame 0xFA with parity forced to 0. Required: `BYTE_READ=8'hFA`, code 2'b01.
- Frame 0x00 (parity 1) with stop forced to 0. Required: code 2'b10.
- Mouse clock stops for 300 µs after 4 data bits, then a valid 0x55 frame (parity 1) follows. Required: no pulse for the partial frame, then `BYTE_READ=8'h55`, code 2'b00.
- `READ_ENABLE=0` during a full 0xFA frame. Required: no pulse and outputs unchanged. Separately, `RESET` pulsed low after 6 bits, then 0x3C (parity 1). Required: outputs at reset values, then 8'h3C with code 2'b00.
